// File: rtl/oserdes_word_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : oserdes_word_feeder
//  Purpose  : Buffers bytes in a small FIFO and presents them to a 4:1 OSERDES
//             as two nibbles per byte (CLKDIV domain). Each burst of bytes is
//             framed by one LEAD nibble and one TRAIL nibble with the line
//             driven; the line is released (T=1111) while idle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH  : byte buffer depth, power of two in 2..16
//    IDLE_NIBBLE : pattern on D1..D4 when no data nibble is being sent
//    LSB_FIRST   : 1 = din[3:0] goes out first, 0 = din[7:4] goes out first
//  Ports
//    clk         : in  - CLKDIV clock, all state changes on rising edge
//    rst         : in  - asynchronous active-high reset, flushes the FIFO
//    din[7:0]    : in  - byte to serialize
//    din_valid   : in  - din holds a valid byte
//    din_ready   : out - byte accepted on this edge if din_valid (comb.)
//    d1..d4      : out - data nibble to OSERDES, d1 is first on the line
//    t1..t4      : out - tristate nibble to OSERDES, 1 = line released
//    oce, tce    : out - OSERDES data / tristate clock enables
//    busy        : out - high whenever the sequencer is not idle
// ============================================================================
module oserdes_word_feeder #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [3:0] IDLE_NIBBLE = 4'b0000,
    parameter bit         LSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       d4,
    output logic       t1,
    output logic       t2,
    output logic       t3,
    output logic       t4,
    output logic       oce,
    output logic       tce,
    output logic       busy
);

    // Pointer width is at least one bit so FIFO_DEPTH=2 still gets a pointer.
    localparam int c_PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    // Count must represent FIFO_DEPTH itself (full), hence depth+1 codes.
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [3:0] c_T_DRIVE   = 4'b0000;
    localparam logic [3:0] c_T_RELEASE = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEAD    = 3'd1,
        ST_DATA_LO = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_TRAIL   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_wr;
    logic               w_rd;
    logic               w_not_empty;
    logic [7:0]         w_head;
    logic [3:0]         w_first_nib;
    logic [3:0]         w_second_nib;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_d;
    logic [3:0]         r_t;
    logic [3:0]         w_next_d;
    logic [3:0]         w_next_t;
    logic               r_oce;
    logic               r_busy;

    // Ready is gated by rst so nothing is accepted while the FIFO is being
    // held flushed.
    assign din_ready   = (r_count < c_CNT_W'(FIFO_DEPTH)) && !rst;
    assign w_wr        = din_valid && din_ready;
    assign w_not_empty = (r_count != '0);

    // The head byte is popped on the edge that leaves DATA_LO (entering
    // DATA_HI); the second nibble is latched into r_d on that same edge, so
    // the byte is no longer needed afterwards.
    assign w_rd        = (r_state == ST_DATA_LO) && w_not_empty;
    assign w_head      = r_mem[r_rptr];

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_first_nib  = w_head[3:0];
            assign w_second_nib = w_head[7:4];
        end else begin : g_msb_first
            assign w_first_nib  = w_head[7:4];
            assign w_second_nib = w_head[3:0];
        end
    endgenerate

    // Storage is not reset; a flush only clears pointers and count.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next state and next outputs. Outputs are a function of the state
    // being entered, so they change on the same edge as r_state.
    // In DATA_HI, r_count already reflects the pop made on entry.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_d     = IDLE_NIBBLE;
        w_next_t     = c_T_RELEASE;

        case (r_state)
            ST_IDLE: begin
                if (w_not_empty) begin
                    w_next_state = ST_LEAD;
                end
            end
            ST_LEAD: begin
                w_next_state = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                w_next_state = ST_DATA_HI;
            end
            ST_DATA_HI: begin
                w_next_state = w_not_empty ? ST_DATA_LO : ST_TRAIL;
            end
            ST_TRAIL: begin
                // A byte arriving during TRAIL rejoins the burst without LEAD.
                w_next_state = w_not_empty ? ST_DATA_LO : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        case (w_next_state)
            ST_LEAD, ST_TRAIL: begin
                w_next_d = IDLE_NIBBLE;
                w_next_t = c_T_DRIVE;
            end
            ST_DATA_LO: begin
                w_next_d = w_first_nib;
                w_next_t = c_T_DRIVE;
            end
            ST_DATA_HI: begin
                w_next_d = w_second_nib;
                w_next_t = c_T_DRIVE;
            end
            default: begin
                w_next_d = IDLE_NIBBLE;
                w_next_t = c_T_RELEASE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_d     <= IDLE_NIBBLE;
            r_t     <= c_T_RELEASE;
            r_oce   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_d     <= w_next_d;
            r_t     <= w_next_t;
            // Clock enables come up on the first edge after reset release
            // and stay up.
            r_oce   <= 1'b1;
            r_busy  <= (w_next_state != ST_IDLE);
        end
    end

    assign d1   = r_d[0];
    assign d2   = r_d[1];
    assign d3   = r_d[2];
    assign d4   = r_d[3];
    assign t1   = r_t[0];
    assign t2   = r_t[1];
    assign t3   = r_t[2];
    assign t4   = r_t[3];
    assign oce  = r_oce;
    assign tce  = r_oce;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_oserdes_word_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oserdes_word_feeder
//  Purpose  : Self-checking bench for oserdes_word_feeder. Stimulus pushes the
//             hand-computed per-cycle output word {oce,tce,busy,T4..T1,D4..D1}
//             tagged with the cycle it is due; a monitor compares on the
//             falling edge. A second instance covers LSB_FIRST=0 and a
//             non-zero IDLE_NIBBLE.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oserdes_word_feeder;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       d1, d2, d3, d4, t1, t2, t3, t4, oce, tce, busy;

    logic [7:0] din2;
    logic       din2_valid;
    logic       din2_ready;
    logic       e1, e2, e3, e4, u1, u2, u3, u4, oce2, tce2, busy2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        bit          sel;
        logic [10:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    // Expected words for the default instance (IDLE_NIBBLE = 0000)
    localparam logic [10:0] IDL  = {2'b11, 1'b0, 4'hF, 4'h0};
    localparam logic [10:0] LT   = {2'b11, 1'b1, 4'h0, 4'h0};
    // Expected words for the second instance (IDLE_NIBBLE = 1010)
    localparam logic [10:0] IDL2 = {2'b11, 1'b0, 4'hF, 4'hA};
    localparam logic [10:0] LT2  = {2'b11, 1'b1, 4'h0, 4'hA};

    logic [7:0] t4_bytes [0:6]  = '{8'h91, 8'hA2, 8'hB3, 8'hC4, 8'hD5, 8'hE6, 8'hF7};
    logic [3:0] t4_nibs  [0:13] = '{4'h1, 4'h9, 4'h2, 4'hA, 4'h3, 4'hB, 4'h4,
                                    4'hC, 4'h5, 4'hD, 4'h6, 4'hE, 4'h7, 4'hF};
    logic       t4_rdy   [0:9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    wire [10:0] out1 = {oce, tce, busy, t4, t3, t2, t1, d4, d3, d2, d1};
    wire [10:0] out2 = {oce2, tce2, busy2, u4, u3, u2, u1, e4, e3, e2, e1};

    oserdes_word_feeder #(
        .FIFO_DEPTH (4),
        .IDLE_NIBBLE(4'b0000),
        .LSB_FIRST  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .t1       (t1),
        .t2       (t2),
        .t3       (t3),
        .t4       (t4),
        .oce      (oce),
        .tce      (tce),
        .busy     (busy)
    );

    oserdes_word_feeder #(
        .FIFO_DEPTH (4),
        .IDLE_NIBBLE(4'b1010),
        .LSB_FIRST  (1'b0)
    ) dut_msb (
        .clk      (clk),
        .rst      (rst),
        .din      (din2),
        .din_valid(din2_valid),
        .din_ready(din2_ready),
        .d1       (e1),
        .d2       (e2),
        .d3       (e3),
        .d4       (e4),
        .t1       (u1),
        .t2       (u2),
        .t3       (u3),
        .t4       (u4),
        .oce      (oce2),
        .tce      (tce2),
        .busy     (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] dat(input logic [3:0] n);
        return {2'b11, 1'b1, 4'h0, n};
    endfunction

    function automatic void push(input int c, input bit s, input logic [10:0] e, input string n);
        exp_t x;
        x.cyc  = c;
        x.sel  = s;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every entry due in the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [10:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = e.sel ? out2 : out1;
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: entry for cycle %0d seen in cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %03h expected %03h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    // Writes one byte on the next rising edge; called 1 time unit after an edge.
    task automatic drive_byte(input bit sel, input logic [7:0] b);
        if (sel) begin
            din2       = b;
            din2_valid = 1'b1;
            chk("wr_ready2", 32'(din2_ready), 32'd1);
        end else begin
            din        = b;
            din_valid  = 1'b1;
            chk("wr_ready", 32'(din_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        din2_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  k;
        int  acc;
        logic rdy;

        rst        = 1'b0;
        din        = 8'h00;
        din_valid  = 1'b0;
        din2       = 8'h00;
        din2_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        din_valid = 1'b1;
        #1;
        // ---------------- reset state ----------------
        chk("rst_t",     32'({t4, t3, t2, t1}), 32'hF);
        chk("rst_d",     32'({d4, d3, d2, d1}), 32'h0);
        chk("rst_oce",   32'(oce), 32'd0);
        chk("rst_tce",   32'(tce), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(din_ready), 32'd0);
        chk("rst_d2",    32'({e4, e3, e2, e1}), 32'hA);
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_oce_pre", 32'(oce), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_oce",   32'(oce), 32'd1);
        chk("rel_tce",   32'(tce), 32'd1);
        chk("rel_busy",  32'(busy), 32'd0);
        chk("rel_t",     32'({t4, t3, t2, t1}), 32'hF);
        chk("rel_ready", 32'(din_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // ---------------- single byte A5 ----------------
        k = cyc + 1;
        push(k,     0, IDL,       "a5_idle_at_write");
        push(k + 1, 0, LT,        "a5_lead");
        push(k + 2, 0, dat(4'h5), "a5_data_lo");
        push(k + 3, 0, dat(4'hA), "a5_data_hi");
        push(k + 4, 0, LT,        "a5_trail");
        push(k + 5, 0, IDL,       "a5_idle");
        drive_byte(0, 8'hA5);
        repeat (6) @(posedge clk);
        #1;

        // ---------------- back-to-back 12 34 56 ----------------
        k = cyc + 1;
        push(k,     0, IDL,       "b2b_idle_at_write");
        push(k + 1, 0, LT,        "b2b_lead");
        push(k + 2, 0, dat(4'h2), "b2b_n0");
        push(k + 3, 0, dat(4'h1), "b2b_n1");
        push(k + 4, 0, dat(4'h4), "b2b_n2");
        push(k + 5, 0, dat(4'h3), "b2b_n3");
        push(k + 6, 0, dat(4'h6), "b2b_n4");
        push(k + 7, 0, dat(4'h5), "b2b_n5");
        push(k + 8, 0, LT,        "b2b_trail");
        push(k + 9, 0, IDL,       "b2b_idle");
        drive_byte(0, 8'h12);
        drive_byte(0, 8'h34);
        drive_byte(0, 8'h56);
        repeat (8) @(posedge clk);
        #1;

        // ---------------- din_valid held for 10 cycles ----------------
        k = cyc + 1;
        push(k,     0, IDL, "hold_idle_at_write");
        push(k + 1, 0, LT,  "hold_lead");
        for (int i = 0; i < 14; i++) begin
            push(k + 2 + i, 0, dat(t4_nibs[i]), $sformatf("hold_nib%0d", i));
        end
        push(k + 16, 0, LT,  "hold_trail");
        push(k + 17, 0, IDL, "hold_idle");
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            din       = (acc < 7) ? t4_bytes[acc] : 8'hEE;
            din_valid = 1'b1;
            rdy       = din_ready;
            chk($sformatf("hold_ready%0d", i), 32'(rdy), 32'(t4_rdy[i]));
            @(posedge clk);
            #1;
            if (rdy) acc++;
        end
        din_valid = 1'b0;
        chk("hold_accepted", 32'(acc), 32'd7);
        repeat (9) @(posedge clk);
        #1;

        // ---------------- write on entry to TRAIL ----------------
        k = cyc + 1;
        push(k,     0, IDL,       "tr_idle_at_write");
        push(k + 1, 0, LT,        "tr_lead");
        push(k + 2, 0, dat(4'hA), "tr_5a_lo");
        push(k + 3, 0, dat(4'h5), "tr_5a_hi");
        push(k + 4, 0, LT,        "tr_trail");
        push(k + 5, 0, dat(4'h3), "tr_c3_lo");
        push(k + 6, 0, dat(4'hC), "tr_c3_hi");
        push(k + 7, 0, LT,        "tr_trail2");
        push(k + 8, 0, IDL,       "tr_idle");
        drive_byte(0, 8'h5A);
        repeat (3) @(posedge clk);
        #1;
        drive_byte(0, 8'hC3);
        repeat (5) @(posedge clk);
        #1;

        // ---------------- reset during DATA_HI ----------------
        k = cyc + 1;
        push(k,     0, IDL,       "rs_idle_at_write");
        push(k + 1, 0, LT,        "rs_lead");
        push(k + 2, 0, dat(4'h1), "rs_lo");
        push(k + 3, 0, dat(4'h1), "rs_hi");
        drive_byte(0, 8'h11);
        drive_byte(0, 8'h22);
        drive_byte(0, 8'h33);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst       = 1'b1;
        din_valid = 1'b1;
        #1;
        chk("mid_rst_t",     32'({t4, t3, t2, t1}), 32'hF);
        chk("mid_rst_oce",   32'(oce), 32'd0);
        chk("mid_rst_tce",   32'(tce), 32'd0);
        chk("mid_rst_ready", 32'(din_ready), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel2_oce",  32'(oce), 32'd1);
        chk("rel2_busy", 32'(busy), 32'd0);
        chk("rel2_t",    32'({t4, t3, t2, t1}), 32'hF);
        k = cyc + 1;
        push(k,     0, IDL,       "rs_0f_idle_at_write");
        push(k + 1, 0, LT,        "rs_0f_lead");
        push(k + 2, 0, dat(4'hF), "rs_0f_lo");
        push(k + 3, 0, dat(4'h0), "rs_0f_hi");
        push(k + 4, 0, LT,        "rs_0f_trail");
        push(k + 5, 0, IDL,       "rs_0f_idle");
        push(k + 6, 0, IDL,       "rs_0f_no_stale");
        drive_byte(0, 8'h0F);
        repeat (7) @(posedge clk);
        #1;

        // ---------------- MSB-first instance, IDLE_NIBBLE=1010 ----------------
        k = cyc + 1;
        push(k,     1, IDL2,      "msb_idle_at_write");
        push(k + 1, 1, LT2,       "msb_lead");
        push(k + 2, 1, dat(4'hA), "msb_lo");
        push(k + 3, 1, dat(4'h5), "msb_hi");
        push(k + 4, 1, LT2,       "msb_trail");
        push(k + 5, 1, IDL2,      "msb_idle");
        drive_byte(1, 8'hA5);
        repeat (7) @(posedge clk);
        #1;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
